// File: rtl/ckpt_free_list_if.sv
// Rename/free-list port bundle: the allocation, free, checkpoint and recovery
// requests driven by the rename stage, plus the free-list status it observes.
interface ckpt_free_list_if #(
    parameter int PHY_REG_NUM = 64,
    parameter int ALLOC_WIDTH = 4,
    parameter int FREE_WIDTH  = 4,
    parameter int CKPT_NUM    = 4
);
    localparam int IW = $clog2(PHY_REG_NUM);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(CKPT_NUM);

    // Handshake: a lane is allocated only when its alloc_valid_i bit is set in
    // a cycle where alloc_ready_o=1; grants are all-or-nothing across lanes.
    // free_ready_o is always 1, so every valid free lane is accepted.
    logic                             flush_i;
    logic [PW-1:0]                    arch_head_i;
    logic [ALLOC_WIDTH-1:0]           alloc_valid_i;
    logic                             alloc_ready_o;
    logic [ALLOC_WIDTH-1:0][IW-1:0]   preg_o;
    logic [FREE_WIDTH-1:0]            free_valid_i;
    logic [FREE_WIDTH-1:0][IW-1:0]    free_preg_i;
    logic                             free_ready_o;
    logic                             ckpt_valid_i;
    logic [CW-1:0]                    ckpt_id_i;
    logic                             restore_valid_i;
    logic [CW-1:0]                    restore_id_i;
    logic [PW-1:0]                    head_o;
    logic [PW-1:0]                    free_cnt_o;
    logic                             overflow_o;

    modport master (
        output flush_i, arch_head_i, alloc_valid_i, free_valid_i, free_preg_i,
               ckpt_valid_i, ckpt_id_i, restore_valid_i, restore_id_i,
        input  alloc_ready_o, preg_o, free_ready_o, head_o, free_cnt_o, overflow_o
    );

    modport slave (
        input  flush_i, arch_head_i, alloc_valid_i, free_valid_i, free_preg_i,
               ckpt_valid_i, ckpt_id_i, restore_valid_i, restore_id_i,
        output alloc_ready_o, preg_o, free_ready_o, head_o, free_cnt_o, overflow_o
    );
endinterface

// File: rtl/ckpt_free_list.sv
// Circular physical-register free list with multi-lane alloc/free and head
// checkpoints for fast branch recovery; flush rewinds head to the arch head.
module ckpt_free_list #(
    parameter int PHY_REG_NUM  = 64,
    parameter int ARCH_REG_NUM = 32,
    parameter int ALLOC_WIDTH  = 4,
    parameter int FREE_WIDTH   = 4,
    parameter int CKPT_NUM     = 4
) (
    input logic            clk,
    input logic            rst,
    ckpt_free_list_if.slave bus
);
    localparam int IW   = $clog2(PHY_REG_NUM);
    localparam int PW   = IW + 1;
    localparam int CNTW = PW + 1;

    logic [IW-1:0] list_q [PHY_REG_NUM];
    logic [PW-1:0] ckpt_q [CKPT_NUM];
    logic [PW-1:0] head_q, tail_q, head_nxt;
    logic          ovf_q;

    logic [PW-1:0] free_cnt, n_a, n_f, a_off, f_off, grant_n;
    logic          grant;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] free_idx [FREE_WIDTH];
    logic [CNTW-1:0] next_cnt;
    logic [ALLOC_WIDTH-1:0][IW-1:0] preg;

    assign free_cnt = tail_q - head_q;

    // Each lane reads past the entries claimed by the valid lanes below it.
    always_comb begin
        a_off  = '0;
        rd_idx = '0;
        preg   = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            rd_idx  = head_q[IW-1:0] + a_off[IW-1:0];
            preg[i] = bus.alloc_valid_i[i] ? list_q[rd_idx] : '0;
            a_off   = a_off + PW'(bus.alloc_valid_i[i]);
        end
        n_a = a_off;
    end

    always_comb begin
        f_off = '0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            free_idx[j] = tail_q[IW-1:0] + f_off[IW-1:0];
            f_off       = f_off + PW'(bus.free_valid_i[j]);
        end
        n_f = f_off;
    end

    // Grant looks only at the registered count, so same-cycle frees never feed it.
    assign grant    = (free_cnt >= n_a) && !bus.flush_i && !bus.restore_valid_i;
    assign grant_n  = grant ? n_a : '0;
    assign next_cnt = CNTW'(free_cnt) + CNTW'(n_f) - CNTW'(grant_n);

    always_comb begin
        if (bus.flush_i)              head_nxt = bus.arch_head_i;
        else if (bus.restore_valid_i) head_nxt = ckpt_q[bus.restore_id_i];
        else                          head_nxt = head_q + grant_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHY_REG_NUM; i++)
                list_q[i] <= (i < PHY_REG_NUM - ARCH_REG_NUM) ? IW'(ARCH_REG_NUM + i) : '0;
            for (int k = 0; k < CKPT_NUM; k++)
                ckpt_q[k] <= '0;
            head_q <= '0;
            tail_q <= PW'(PHY_REG_NUM - ARCH_REG_NUM);
            ovf_q  <= 1'b0;
        end else begin
            for (int j = 0; j < FREE_WIDTH; j++)
                if (bus.free_valid_i[j])
                    list_q[free_idx[j]] <= bus.free_preg_i[j];
            tail_q <= tail_q + n_f;
            head_q <= head_nxt;
            if (bus.ckpt_valid_i && !bus.flush_i && !bus.restore_valid_i)
                ckpt_q[bus.ckpt_id_i] <= head_nxt;
            if (next_cnt > CNTW'(PHY_REG_NUM))
                ovf_q <= 1'b1;
        end
    end

    assign bus.alloc_ready_o = grant;
    assign bus.preg_o        = preg;
    assign bus.free_ready_o  = 1'b1;
    assign bus.head_o        = head_q;
    assign bus.free_cnt_o    = free_cnt;
    assign bus.overflow_o    = ovf_q;
endmodule

// File: tb/tb_ckpt_free_list.sv
// Bench for ckpt_free_list: reset table, directed recovery/wrap/overflow
// sequences and a random run compared against an array-based reference model.
module tb_ckpt_free_list;
    localparam int PHY = 64;
    localparam int ARCH = 32;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int CN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ckpt_free_list_if #(.PHY_REG_NUM(PHY), .ALLOC_WIDTH(AW), .FREE_WIDTH(FW), .CKPT_NUM(CN)) bus ();

    ckpt_free_list #(
        .PHY_REG_NUM(PHY), .ARCH_REG_NUM(ARCH), .ALLOC_WIDTH(AW),
        .FREE_WIDTH(FW), .CKPT_NUM(CN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: list contents, head/tail as plain integers modulo 128.
    int m_list [PHY];
    int m_ckpt [CN];
    int m_head, m_tail;
    bit m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int popc(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int m_cnt();
        return (m_tail - m_head) & 127;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PHY; i++) m_list[i] = (i < PHY - ARCH) ? ARCH + i : 0;
        for (int k = 0; k < CN; k++) m_ckpt[k] = 0;
        m_head = 0;
        m_tail = PHY - ARCH;
        m_ovf  = 1'b0;
    endtask

    task automatic idle();
        bus.flush_i = 1'b0;
        bus.arch_head_i = '0;
        bus.alloc_valid_i = '0;
        bus.free_valid_i = '0;
        bus.free_preg_i = '0;
        bus.ckpt_valid_i = 1'b0;
        bus.ckpt_id_i = '0;
        bus.restore_valid_i = 1'b0;
        bus.restore_id_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset head", 32'(bus.head_o), 0);
        check("reset free_cnt", 32'(bus.free_cnt_o), 32);
        check("reset overflow", 32'(bus.overflow_o), 0);
    endtask

    // One clock with the currently driven inputs: comb outputs checked before
    // the edge, model advanced, registered outputs checked after it.
    task automatic cycle(input string tag);
        int na, nf, cnt, off, nh;
        bit g;
        #1;
        na  = popc(bus.alloc_valid_i);
        nf  = popc(bus.free_valid_i);
        cnt = m_cnt();
        g   = (cnt >= na) && !bus.flush_i && !bus.restore_valid_i;
        check({tag, " alloc_ready"}, 32'(bus.alloc_ready_o), 32'(g));
        check({tag, " free_ready"}, 32'(bus.free_ready_o), 1);
        off = 0;
        for (int i = 0; i < AW; i++) begin
            check($sformatf("%s preg%0d", tag, i), 32'(bus.preg_o[i]),
                  bus.alloc_valid_i[i] ? m_list[(m_head + off) & 63] : 0);
            off += int'(bus.alloc_valid_i[i]);
        end
        @(posedge clk);
        off = 0;
        for (int j = 0; j < FW; j++) begin
            if (bus.free_valid_i[j]) begin
                m_list[(m_tail + off) & 63] = int'(bus.free_preg_i[j]);
                off++;
            end
        end
        if (cnt + nf - (g ? na : 0) > PHY) m_ovf = 1'b1;
        if (bus.flush_i)              nh = int'(bus.arch_head_i);
        else if (bus.restore_valid_i) nh = m_ckpt[bus.restore_id_i];
        else                          nh = (m_head + (g ? na : 0)) & 127;
        if (bus.ckpt_valid_i && !bus.flush_i && !bus.restore_valid_i) m_ckpt[bus.ckpt_id_i] = nh;
        m_head = nh;
        m_tail = (m_tail + nf) & 127;
        #1;
        check({tag, " head"}, 32'(bus.head_o), 32'(m_head));
        check({tag, " free_cnt"}, 32'(bus.free_cnt_o), 32'(m_cnt()));
        check({tag, " overflow"}, 32'(bus.overflow_o), 32'(m_ovf));
    endtask

    typedef struct {
        logic [3:0] mask;
        int         p [4];
        int         cnt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        idle();
        vecs[0] = '{mask: 4'b1111, p: '{32, 33, 34, 35}, cnt: 28};
        vecs[1] = '{mask: 4'b1010, p: '{0, 32, 0, 33},   cnt: 30};
        vecs[2] = '{mask: 4'b0001, p: '{32, 0, 0, 0},    cnt: 31};
        vecs[3] = '{mask: 4'b0000, p: '{0, 0, 0, 0},     cnt: 32};
        vecs[4] = '{mask: 4'b0110, p: '{0, 32, 33, 0},   cnt: 30};
        vecs[5] = '{mask: 4'b1000, p: '{0, 0, 0, 32},    cnt: 31};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.alloc_valid_i = vecs[v].mask;
            #1;
            check($sformatf("vec%0d ready", v), 32'(bus.alloc_ready_o), 1);
            for (int i = 0; i < AW; i++)
                check($sformatf("vec%0d lane%0d", v, i), 32'(bus.preg_o[i]), 32'(vecs[v].p[i]));
            cycle($sformatf("vec%0d", v));
            check($sformatf("vec%0d cnt", v), 32'(bus.free_cnt_o), 32'(vecs[v].cnt));
            check($sformatf("vec%0d head", v), 32'(bus.head_o), 32'(32 - vecs[v].cnt));
        end

        // Grant refused at count 3, same-cycle free not usable until next cycle.
        do_reset();
        bus.alloc_valid_i = 4'b1111;
        for (int k = 0; k < 7; k++) cycle("drain");
        bus.alloc_valid_i = 4'b0001;
        cycle("drain1");
        check("short cnt", 32'(bus.free_cnt_o), 3);
        bus.alloc_valid_i = 4'b1111;
        bus.free_valid_i = 4'b0001;
        bus.free_preg_i[0] = 6'd5;
        #1;
        check("short ready", 32'(bus.alloc_ready_o), 0);
        cycle("short");
        check("short head", 32'(bus.head_o), 29);
        check("short cnt4", 32'(bus.free_cnt_o), 4);
        bus.free_valid_i = '0;
        bus.alloc_valid_i = 4'b0111;
        #1;
        check("three ready", 32'(bus.alloc_ready_o), 1);
        cycle("three");
        check("three head", 32'(bus.head_o), 32);
        check("three cnt", 32'(bus.free_cnt_o), 1);

        // Checkpoint then restore with concurrent frees.
        do_reset();
        bus.alloc_valid_i = 4'b1111;
        cycle("pre");
        bus.ckpt_valid_i = 1'b1;
        bus.ckpt_id_i = 2'd2;
        cycle("ckpt");
        bus.ckpt_valid_i = 1'b0;
        cycle("run1");
        cycle("run2");
        check("run head", 32'(bus.head_o), 16);
        bus.restore_valid_i = 1'b1;
        bus.restore_id_i = 2'd2;
        bus.free_valid_i = 4'b0011;
        bus.free_preg_i[0] = 6'd7;
        bus.free_preg_i[1] = 6'd9;
        #1;
        check("restore ready", 32'(bus.alloc_ready_o), 0);
        cycle("restore");
        check("restore head", 32'(bus.head_o), 8);
        check("restore cnt", 32'(bus.free_cnt_o), 26);
        idle();

        // Flush wins over restore and suppresses the checkpoint write.
        do_reset();
        bus.flush_i = 1'b1;
        bus.arch_head_i = 7'd20;
        bus.restore_valid_i = 1'b1;
        bus.restore_id_i = 2'd1;
        bus.ckpt_valid_i = 1'b1;
        bus.ckpt_id_i = 2'd1;
        bus.alloc_valid_i = 4'b1111;
        cycle("flush");
        check("flush head", 32'(bus.head_o), 20);
        idle();
        bus.restore_valid_i = 1'b1;
        bus.restore_id_i = 2'd1;
        cycle("slot1");
        check("slot1 unwritten", 32'(bus.head_o), 0);
        idle();

        // Wrap across the end of the list.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            bus.alloc_valid_i = 4'b1111;
            bus.free_valid_i = 4'b1111;
            for (int j = 0; j < FW; j++) bus.free_preg_i[j] = 6'(40 + j);
            cycle("fill");
        end
        idle();
        bus.alloc_valid_i = 4'b0011;
        cycle("to62");
        check("to62 head", 32'(bus.head_o), 62);
        bus.alloc_valid_i = 4'b1111;
        #1;
        check("wrap lane0", 32'(bus.preg_o[0]), 42);
        check("wrap lane1", 32'(bus.preg_o[1]), 43);
        check("wrap lane2", 32'(bus.preg_o[2]), 40);
        check("wrap lane3", 32'(bus.preg_o[3]), 41);
        cycle("wrap");
        check("wrap head", 32'(bus.head_o), 66);
        idle();

        // Overflow: 32 frees reach the limit, the 33rd trips the sticky flag.
        do_reset();
        bus.free_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++) cycle("fill64");
        check("full no ovf", 32'(bus.overflow_o), 0);
        check("full cnt", 32'(bus.free_cnt_o), 64);
        bus.free_valid_i = 4'b0001;
        cycle("ovf");
        check("ovf set", 32'(bus.overflow_o), 1);
        idle();
        for (int k = 0; k < 3; k++) cycle("ovf hold");
        check("ovf sticky", 32'(bus.overflow_o), 1);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.alloc_valid_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) bus.free_valid_i = 4'($urandom_range(0, 15));
            for (int j = 0; j < FW; j++) bus.free_preg_i[j] = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 31) == 0) begin
                bus.flush_i = 1'b1;
                bus.arch_head_i = 7'((m_tail - int'($urandom_range(0, 40))) & 127);
            end
            if ($urandom_range(0, 15) == 0) begin
                bus.restore_valid_i = 1'b1;
                bus.restore_id_i = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.ckpt_valid_i = 1'b1;
                bus.ckpt_id_i = 2'($urandom_range(0, 3));
            end
            cycle("rand");
        end

        // Reset mid-traffic overrides everything.
        bus.alloc_valid_i = 4'b1111;
        bus.restore_valid_i = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        model_reset();
        check("rst override head", 32'(bus.head_o), 0);
        check("rst override cnt", 32'(bus.free_cnt_o), 32);
        check("rst override ovf", 32'(bus.overflow_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
